// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: arbiter states, default bus
// sizes reused by the master ports, and the slave-enable decode.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SEL,
    ROUTE,
    RELEASE
  } state_t;

  localparam int BUS_NUM_MASTERS = 2;
  localparam int BUS_SLAVE_LEN   = 2;

  // One bit of the one-hot slave decode: true when slave_idx is the addressed slave.
  function automatic logic slave_hit(input int unsigned slave_id, input int unsigned slave_idx);
    return slave_id == slave_idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selection: first requesting index strictly after
// last, wrapping modulo N.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate down so the nearest one after last wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % N);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serial system bus arbiter: round-robin grant, serial slave-select capture,
// one-hot slave enable, and ownership release on done, request drop or watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = BUS_NUM_MASTERS,
  parameter int SLAVE_LEN   = BUS_SLAVE_LEN,
  parameter int TIMEOUT     = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [NUM_MASTERS-1:0]         ssel,
  input  logic [NUM_MASTERS-1:0]         done,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic                           busy,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           owner_valid,
  output logic [SLAVE_LEN-1:0]           slave_id,
  output logic [2**SLAVE_LEN-1:0]        slave_en,
  output logic                           timeout
);

  localparam int OW   = $clog2(NUM_MASTERS);
  localparam int NSLV = 2**SLAVE_LEN;
  localparam int CW   = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;
  localparam int WW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                   state_q, state_d;
  logic [OW-1:0]            owner_q, owner_d;
  logic [OW-1:0]            last_q, last_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [WW-1:0]            wd_q, wd_d;
  logic [SLAVE_LEN-1:0]     slave_id_q, slave_id_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic                     busy_q, busy_d;
  logic                     owner_valid_q, owner_valid_d;
  logic [NSLV-1:0]          slave_en_q, slave_en_d;
  logic                     timeout_q, timeout_d;

  logic [OW-1:0]            winner;
  logic                     any_valid;
  logic                     owner_req;
  logic                     owner_done;
  logic                     owner_ssel;

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (OW)
  ) u_rr_picker (
    .req       (req),
    .last      (last_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign owner_req  = req[owner_q];
  assign owner_done = done[owner_q];
  assign owner_ssel = ssel[owner_q];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    slave_id_d = slave_id_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        grant_d = '0;
        if (any_valid) begin
          owner_d = winner;
          grant_d = NUM_MASTERS'(1) << winner;
          busy_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (!owner_req) begin
          state_d = RELEASE;
        end else begin
          state_d = SEL;
          cnt_d   = '0;
        end
      end
      SEL: begin
        wd_d = '0;
        if (!owner_req) begin
          state_d = RELEASE;
        end else begin
          slave_id_d[cnt_q] = owner_ssel;
          cnt_d             = cnt_q + 1'b1;
          if (cnt_q == CW'(SLAVE_LEN - 1)) state_d = ROUTE;
        end
      end
      ROUTE: begin
        wd_d = wd_q + 1'b1;
        // done outranks the watchdog, so a same-cycle expiry raises no pulse.
        if (owner_done || !owner_req) begin
          state_d = RELEASE;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        last_d  = owner_q;
        busy_d  = 1'b0;
        wd_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RELEASE) grant_d = '0;
    // Enables follow the registered ROUTE state and drop on the releasing edge.
    owner_valid_d = (state_q == ROUTE) && (state_d == ROUTE);
  end

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slave_en
    assign slave_en_d[gi] = owner_valid_d & slave_hit(32'(slave_id_q), 32'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_q        <= OW'(NUM_MASTERS - 1);
      cnt_q         <= '0;
      wd_q          <= '0;
      slave_id_q    <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      owner_valid_q <= 1'b0;
      slave_en_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      slave_id_q    <= slave_id_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      owner_valid_q <= owner_valid_d;
      slave_en_q    <= slave_en_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;
  assign slave_id    = slave_id_q;
  assign slave_en    = slave_en_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed transactions push expected
// per-transaction summaries; a monitor pops and compares at each busy release.
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int SL = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] req;
  logic [NM-1:0] ssel;
  logic [NM-1:0] done;
  logic [NM-1:0] grant;
  logic          busy;
  logic [0:0]    owner;
  logic          owner_valid;
  logic [SL-1:0] slave_id;
  logic [3:0]    slave_en;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] grant;
    logic       owner;
    logic [3:0] slv;
    logic       ov;
    int         to;
    int         len;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_MASTERS (NM),
    .SLAVE_LEN   (SL),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ssel        (ssel),
    .done        (done),
    .grant       (grant),
    .busy        (busy),
    .owner       (owner),
    .owner_valid (owner_valid),
    .slave_id    (slave_id),
    .slave_en    (slave_en),
    .timeout     (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Monitor: summarise each busy period and compare it with the next expected entry.
  initial begin : monitor
    logic in_txn;
    exp_t cur;
    exp_t e;
    in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn = 1'b0;
      end else begin
        if (busy && !in_txn) begin
          in_txn    = 1'b1;
          cur.grant = grant;
          cur.owner = owner[0];
          cur.slv   = '0;
          cur.ov    = 1'b0;
          cur.to    = 0;
          cur.len   = 0;
        end
        if (in_txn && busy) begin
          cur.len++;
          cur.slv = cur.slv | slave_en;
          cur.ov  = cur.ov | owner_valid;
          cur.to  = cur.to + int'(timeout);
        end else if (in_txn) begin
          in_txn = 1'b0;
          $display("txn grant=%b owner=%0d slave_en_seen=%b owner_valid_seen=%b timeouts=%0d busy_cycles=%0d",
                   cur.grant, cur.owner, cur.slv, cur.ov, cur.to, cur.len);
          check("sb_pending", 32'(sb.size() > 0), 32'(1));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("txn_grant",       32'(cur.grant), 32'(e.grant));
            check("txn_owner",       32'(cur.owner), 32'(e.owner));
            check("txn_slave_en",    32'(cur.slv),   32'(e.slv));
            check("txn_owner_valid", 32'(cur.ov),    32'(e.ov));
            check("txn_timeouts",    32'(cur.to),    32'(e.to));
            check("txn_busy_cycles", 32'(cur.len),   32'(e.len));
          end
        end
      end
    end
  end

  task automatic wait_grant(input int m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!grant[m] && n < 30);
    check("grant_wait", 32'(grant[m]), 32'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    check("busy_clear", 32'(busy), 32'(0));
  endtask

  // Called just after the grant edge; slave bit k is sampled at grant edge + 2 + k.
  task automatic shift_in(input int m, input logic [1:0] id);
    ssel[m] = id[0];
    @(posedge clk);
    @(posedge clk);
    #1 ssel[m] = id[1];
    @(posedge clk);
    #1;
  endtask

  // Full transaction: done sampled at grant edge + 4 + k.
  task automatic run_txn(input int m, input logic [1:0] id, input int k, input logic drop, input exp_t e);
    sb.push_back(e);
    req[m] = 1'b1;
    wait_grant(m);
    shift_in(m, id);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    done[m] = 1'b1;
    @(posedge clk);
    #1;
    done[m] = 1'b0;
    if (drop) req[m] = 1'b0;
  endtask

  // Request drop sampled at grant edge + at (1 = GAP, 2 = first SEL cycle).
  task automatic run_abort(input int m, input int at, input exp_t e);
    sb.push_back(e);
    req[m] = 1'b1;
    wait_grant(m);
    ssel[m] = 1'b1;
    repeat (at - 1) begin
      @(posedge clk);
      #1;
    end
    req[m] = 1'b0;
    wait_idle();
    ssel[m] = 1'b0;
  endtask

  task automatic run_timeout(input int m, input logic [1:0] id, input exp_t e);
    sb.push_back(e);
    req[m] = 1'b1;
    wait_grant(m);
    shift_in(m, id);
    wait_idle();
    req[m] = 1'b0;
  endtask

  initial begin : guard
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : driver
    reset = 1'b1;
    req   = '0;
    ssel  = '0;
    done  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant",       32'(grant),       32'(0));
    check("rst_busy",        32'(busy),        32'(0));
    check("rst_owner_valid", 32'(owner_valid), 32'(0));
    check("rst_slave_en",    32'(slave_en),    32'(0));
    check("rst_timeout",     32'(timeout),     32'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single request: slave 1, done at grant edge + 10.
    run_txn(0, 2'b01, 6, 1'b1, '{2'b01, 1'b0, 4'b0010, 1'b1, 0, 11});
    // Shortest transaction: done on the first ROUTE edge, no enable ever shown.
    run_txn(1, 2'b11, 0, 1'b1, '{2'b10, 1'b1, 4'b0000, 1'b0, 0, 5});

    // Both masters requesting: m0, then m1 despite m0 re-requesting, then m0.
    req = 2'b11;
    run_txn(0, 2'b10, 1, 1'b1, '{2'b01, 1'b0, 4'b0100, 1'b1, 0, 6});
    req[0] = 1'b1;
    run_txn(1, 2'b00, 2, 1'b0, '{2'b10, 1'b1, 4'b0001, 1'b1, 0, 7});
    run_txn(0, 2'b11, 1, 1'b1, '{2'b01, 1'b0, 4'b1000, 1'b1, 0, 6});
    req[1] = 1'b0;

    // Request drop in GAP and in SEL.
    run_abort(0, 1, '{2'b01, 1'b0, 4'b0000, 1'b0, 0, 2});
    run_abort(1, 2, '{2'b10, 1'b1, 4'b0000, 1'b0, 0, 3});

    // Watchdog expiry, then done arriving in the expiry cycle.
    run_timeout(0, 2'b01, '{2'b01, 1'b0, 4'b0010, 1'b1, 1, 12});
    run_txn(1, 2'b10, 7, 1'b1, '{2'b10, 1'b1, 4'b0100, 1'b1, 0, 12});

    // Leave last pointing at master 0, then reset in the middle of ROUTE.
    run_txn(0, 2'b00, 1, 1'b1, '{2'b01, 1'b0, 4'b0001, 1'b1, 0, 6});
    req[0] = 1'b1;
    wait_grant(0);
    shift_in(0, 2'b01);
    @(posedge clk);
    #3;
    check("pre_reset_slave_en", 32'(slave_en), 32'(4'b0010));
    reset = 1'b1;
    #1;
    check("async_grant",       32'(grant),       32'(0));
    check("async_busy",        32'(busy),        32'(0));
    check("async_owner",       32'(owner),       32'(0));
    check("async_owner_valid", 32'(owner_valid), 32'(0));
    check("async_slave_id",    32'(slave_id),    32'(0));
    check("async_slave_en",    32'(slave_en),    32'(0));
    check("async_timeout",     32'(timeout),     32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 2'b11;
    ssel  = '0;
    done  = '0;
    run_txn(0, 2'b01, 2, 1'b1, '{2'b01, 1'b0, 4'b0010, 1'b1, 0, 7});
    req[1] = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
